// File: rtl/multicycle_controller.sv
// multicycle_controller: LEGv8 multi-cycle control sequencer.
// Steps FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, counts retires.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg2loc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        link,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ILL,
        C_B,
        C_BL,
        C_CBZ,
        C_CBNZ,
        C_LDUR,
        C_STUR,
        C_R,
        C_I
    } cls_t;

    state_t      st_q;
    state_t      st_d;
    cls_t        cls_q;
    cls_t        cls_dec;
    logic [15:0] ret_q;
    logic        done;
    logic        unused;

    // Operand fields are consumed by the datapath, not here.
    assign unused = ^instr[20:0];

    assign state   = st_q;
    assign retired = ret_q;

    function automatic logic uses_rt(input cls_t c);
        return (c == C_STUR) || (c == C_CBZ) || (c == C_CBNZ);
    endfunction

    // Classify the IR word; the opcode groups are mutually exclusive.
    always_comb begin
        cls_dec = C_ILL;
        unique case (1'b1)
            (instr[31:26] == 6'b000101):       cls_dec = C_B;
            (instr[31:26] == 6'b100101):       cls_dec = C_BL;
            (instr[31:24] == 8'b10110100):     cls_dec = C_CBZ;
            (instr[31:24] == 8'b10110101):     cls_dec = C_CBNZ;
            (instr[31:21] == 11'b11111000010): cls_dec = C_LDUR;
            (instr[31:21] == 11'b11111000000): cls_dec = C_STUR;
            (instr[31:21] == 11'b10001011000): cls_dec = C_R;
            (instr[31:21] == 11'b11001011000): cls_dec = C_R;
            (instr[31:21] == 11'b10001010000): cls_dec = C_R;
            (instr[31:21] == 11'b10101010000): cls_dec = C_R;
            (instr[31:22] == 10'b1001000100):  cls_dec = C_I;
            (instr[31:22] == 10'b1101000100):  cls_dec = C_I;
            default:                           cls_dec = C_ILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Latch the instruction class in DECODE for the rest of the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q <= C_ILL;
        end else if (st_q == S_DECODE) begin
            cls_q <= cls_dec;
        end
    end

    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_q <= 16'd0;
        end else if (done) begin
            ret_q <= ret_q + 16'd1;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        st_d       = st_q;
        done       = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        reg2loc    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        halted     = 1'b0;

        // ALU setup and reg2loc stay stable for the whole instruction.
        if ((st_q == S_EXEC) || (st_q == S_MEM) || (st_q == S_WB)) begin
            reg2loc = uses_rt(cls_q);
            unique case (cls_q)
                C_R: begin
                    alu_op = 2'b10;
                end
                C_I: begin
                    alu_op  = 2'b10;
                    alu_src = 1'b1;
                end
                C_LDUR, C_STUR: begin
                    alu_op  = 2'b00;
                    alu_src = 1'b1;
                end
                C_CBZ, C_CBNZ: begin
                    alu_op = 2'b01;
                end
                default: begin
                    alu_op = 2'b00;
                end
            endcase
        end

        case (st_q)
            S_IDLE: begin
                if (run) begin
                    st_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    st_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                reg2loc = uses_rt(cls_dec);
                st_d    = (cls_dec == C_ILL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                unique case (cls_q)
                    C_R, C_I: begin
                        st_d = S_WB;
                    end
                    C_LDUR, C_STUR: begin
                        st_d = S_MEM;
                    end
                    C_CBZ: begin
                        pc_write = zero;
                        pc_src   = zero ? 2'b01 : 2'b00;
                        done     = 1'b1;
                    end
                    C_CBNZ: begin
                        pc_write = !zero;
                        pc_src   = zero ? 2'b00 : 2'b01;
                        done     = 1'b1;
                    end
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                        done     = 1'b1;
                    end
                    C_BL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b01;
                        reg_write = 1'b1;
                        link      = 1'b1;
                        done      = 1'b1;
                    end
                    default: begin
                        st_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STUR);
                if (dmem_ready) begin
                    if (cls_q == C_STUR) begin
                        done = 1'b1;
                    end else begin
                        st_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LDUR);
                done       = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase

        // run is only consulted once the instruction has finished.
        if (done) begin
            st_d = run ? S_FETCH : S_IDLE;
        end
    end

endmodule
